id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the MINAv2 core, with a load-use hazard detector.
- Captures decoded operands and control from ID and presents them to EX and to the forwarding unit (ra/rb addresses, registered).
- Inserts bubbles and stalls IF/ID when the forwarding unit cannot resolve a hazard, i.e. a load result needed by the next instruction.
- Also honours external hold (MEM busy) and branch flush.

Parameters:
LOAD_USE_CYCLES, 1, number of bubbles inserted per load-use hazard; legal range 1..3.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
valid_id  in  1  ID holds a real instruction
ra_addr_id  in  regaddr_t  source A address
rb_addr_id  in  regaddr_t  source B address
rd_addr_id  in  regaddr_t  destination address
ra_data_id  in  u32_t  register file read A
rb_data_id  in  u32_t  register file read B
imm_id  in  u32_t  decoded immediate
ctrl_id  in  ex_ctrl_t  alu_op, mem_rd, mem_wr, reg_we
hold_mem  in  1  MEM busy; freeze pipeline
flush_ex  in  1  taken branch/exception; kill ID/EX contents
valid_id_ex  out  1  ID/EX holds a real instruction
ra_addr_id_ex, rb_addr_id_ex, rd_addr_id_ex  out  regaddr_t  to fw_unit and EX
ra_data_id_ex, rb_data_id_ex, imm_id_ex  out  u32_t  to EX operand muxes
ctrl_id_ex  out  ex_ctrl_t  to EX
stall_id  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset (async, rst_n low):
  - all outputs 0; ctrl_id_ex = EX_CTRL_NOP; valid_id_ex = 0.
  - state = HZ_RUN; bubble counter = 0.
- Bubble definition: valid = 0, all addresses 0, data 0, ctrl = EX_CTRL_NOP (reg_we = 0, mem_rd = 0, mem_wr = 0).
- Hazard detect (combinational):
  - condition: valid_id_ex & ctrl_id_ex.mem_rd & rd_addr_id_ex != 0 & valid_id & (rd_addr_id_ex == ra_addr_id | rd_addr_id_ex == rb_addr_id).
  - both operands matching counts as one hazard.
- Per-edge priority, highest first:
  1. flush_ex: load bubble; state -> HZ_RUN; counter -> 0. Overrides hold_mem.
  2. hold_mem: all registers and counter unchanged; stall_id = 1.
  3. state HZ_RUN with hazard: load bubble; stall_id = 1.
     - LOAD_USE_CYCLES == 1: stay in HZ_RUN.
     - otherwise: counter <= LOAD_USE_CYCLES-1; state -> HZ_LU_WAIT.
  4. state HZ_LU_WAIT: load bubble; stall_id = 1; counter decrements. When counter reaches 1 -> HZ_RUN; ID is captured on the following edge.
  5. Otherwise: capture all _id inputs; valid_id_ex <= valid_id; stall_id = 0.
- stall_id = hold_mem | (hazard & state == HZ_RUN) | (state == HZ_LU_WAIT), gated to 0 when flush_ex = 1.
- Latency: one cycle ID -> EX for non-hazard instructions; a load-use consumer is delayed by LOAD_USE_CYCLES cycles.
- Because a bubble has rd = 0 and reg_we = 0, no downstream forward from a bubble can corrupt non-zero registers.
- Reset mid-stall: returns to HZ_RUN immediately; no stale bubble count survives.

Optional Feature:
MINA_ID_EX_PERF_CNT_EN
- With macro defined: adds outputs perf_bubbles (u32_t) and perf_holds (u32_t).
  - perf_bubbles counts edges on which a load-use bubble is loaded (flush bubbles excluded).
  - perf_holds counts edges with hold_mem = 1 and flush_ex = 0.
  - Both wrap modulo 2^32 and reset to 0.
- Without macro: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package types: ex_ctrl_t struct, alu_op_e, EX_CTRL_NOP constant, hz_state_e {HZ_RUN, HZ_LU_WAIT}; regaddr_t and u32_t already present.
- One sub-module, load_use_detect: purely combinational hazard compare, reused by future dual-issue work.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0, valid_id_ex = 0, stall_id = 0. Release -> first valid ID instruction appears on outputs after 1 edge.
- Load r3 followed by add r5, r3, r4, LOAD_USE_CYCLES = 1 -> stall_id = 1 for exactly 1 cycle. ID/EX shows bubble then add; ra_addr_id_ex = 3 when the load is in MEM/WB.
- Same sequence with LOAD_USE_CYCLES = 3 -> 3 consecutive bubbles, stall_id high 3 cycles, add captured on the 4th edge.
- Load r0 followed by a use of r0 -> no stall, no bubble.
- hold_mem = 1 for 2 cycles during HZ_LU_WAIT (counter = 2) -> outputs and counter frozen. After release, remaining bubbles complete; total stall = 2 + 3 cycles.
- flush_ex together with hold_mem and a pending hazard -> bubble loaded, state HZ_RUN, stall_id = 0. With perf enabled, perf_bubbles unchanged and perf_holds unchanged.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the MINAv2 ID/EX stage: operand/control records, ALU ops and hazard FSM states.
package id_ex_stage_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] u32_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_we;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NOP = '{alu_op: ALU_ADD, mem_rd: 1'b0, mem_wr: 1'b0, reg_we: 1'b0};

  typedef enum logic {HZ_RUN, HZ_LU_WAIT} hz_state_e;

  typedef struct packed {
    logic     valid;
    regaddr_t ra_addr;
    regaddr_t rb_addr;
    regaddr_t rd_addr;
    u32_t     ra_data;
    u32_t     rb_data;
    u32_t     imm;
    ex_ctrl_t ctrl;
  } id_ex_t;

  // rd = 0 and reg_we = 0 keep a bubble from ever forwarding into a live register.
  localparam id_ex_t ID_EX_BUBBLE = '{
    valid: 1'b0, ra_addr: '0, rb_addr: '0, rd_addr: '0,
    ra_data: '0, rb_data: '0, imm: '0, ctrl: EX_CTRL_NOP
  };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare between the instruction in ID/EX and the one in ID.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic     valid_ex_i,
  input  logic     mem_rd_ex_i,
  input  regaddr_t rd_addr_ex_i,
  input  logic     valid_id_i,
  input  regaddr_t ra_addr_id_i,
  input  regaddr_t rb_addr_id_i,
  output logic     hazard_o
);

  always_comb begin
    hazard_o = valid_ex_i && mem_rd_ex_i && (rd_addr_ex_i != '0) && valid_id_i &&
               ((rd_addr_ex_i == ra_addr_id_i) || (rd_addr_ex_i == rb_addr_id_i));
  end

endmodule

// File: rtl/id_ex_stage.sv
// MINAv2 ID/EX pipeline register with load-use bubble insertion, MEM hold and branch flush.
// Optional perf counters (perf_bubbles, perf_holds) enabled by MINA_ID_EX_PERF_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     valid_id,
  input  regaddr_t ra_addr_id,
  input  regaddr_t rb_addr_id,
  input  regaddr_t rd_addr_id,
  input  u32_t     ra_data_id,
  input  u32_t     rb_data_id,
  input  u32_t     imm_id,
  input  ex_ctrl_t ctrl_id,
  input  logic     hold_mem,
  input  logic     flush_ex,
  output logic     valid_id_ex,
  output regaddr_t ra_addr_id_ex,
  output regaddr_t rb_addr_id_ex,
  output regaddr_t rd_addr_id_ex,
  output u32_t     ra_data_id_ex,
  output u32_t     rb_data_id_ex,
  output u32_t     imm_id_ex,
  output ex_ctrl_t ctrl_id_ex,
  output logic     stall_id
`ifdef MINA_ID_EX_PERF_CNT_EN
  ,
  output u32_t     perf_bubbles,
  output u32_t     perf_holds
`endif
);

  id_ex_t     pipe_q, pipe_d;
  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       hazard;
  logic       lu_bubble;

  load_use_detect u_lud (
    .valid_ex_i   (pipe_q.valid),
    .mem_rd_ex_i  (pipe_q.ctrl.mem_rd),
    .rd_addr_ex_i (pipe_q.rd_addr),
    .valid_id_i   (valid_id),
    .ra_addr_id_i (ra_addr_id),
    .rb_addr_id_i (rb_addr_id),
    .hazard_o     (hazard)
  );

  always_comb begin
    stall_id = !flush_ex &&
               (hold_mem || (hazard && state_q == HZ_RUN) || (state_q == HZ_LU_WAIT));
  end

  always_comb begin
    pipe_d    = pipe_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    lu_bubble = 1'b0;
    if (flush_ex) begin
      pipe_d  = ID_EX_BUBBLE;
      state_d = HZ_RUN;
      cnt_d   = '0;
    end else if (hold_mem) begin
      pipe_d = pipe_q;
    end else if (state_q == HZ_LU_WAIT) begin
      pipe_d    = ID_EX_BUBBLE;
      lu_bubble = 1'b1;
      // Leaving on count 1 makes this edge the last bubble; ID is taken on the next one.
      if (cnt_q == 2'd1) begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (hazard) begin
      pipe_d    = ID_EX_BUBBLE;
      lu_bubble = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        cnt_d   = 2'(LOAD_USE_CYCLES - 1);
        state_d = HZ_LU_WAIT;
      end
    end else begin
      pipe_d = '{valid: valid_id, ra_addr: ra_addr_id, rb_addr: rb_addr_id,
                 rd_addr: rd_addr_id, ra_data: ra_data_id, rb_data: rb_data_id,
                 imm: imm_id, ctrl: ctrl_id};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q  <= ID_EX_BUBBLE;
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      pipe_q  <= pipe_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_id_ex   = pipe_q.valid;
  assign ra_addr_id_ex = pipe_q.ra_addr;
  assign rb_addr_id_ex = pipe_q.rb_addr;
  assign rd_addr_id_ex = pipe_q.rd_addr;
  assign ra_data_id_ex = pipe_q.ra_data;
  assign rb_data_id_ex = pipe_q.rb_data;
  assign imm_id_ex     = pipe_q.imm;
  assign ctrl_id_ex    = pipe_q.ctrl;

`ifdef MINA_ID_EX_PERF_CNT_EN
  u32_t perf_bubbles_q, perf_holds_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles_q <= '0;
      perf_holds_q   <= '0;
    end else begin
      if (lu_bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (hold_mem && !flush_ex) perf_holds_q <= perf_holds_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: instance 0 uses LOAD_USE_CYCLES=1, instance 1 uses 3.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     valid_id;
  regaddr_t ra_addr_id, rb_addr_id, rd_addr_id;
  u32_t     ra_data_id, rb_data_id, imm_id;
  ex_ctrl_t ctrl_id;
  logic     hold_mem, flush_ex;

  logic     valid_o [2];
  regaddr_t ra_o    [2];
  regaddr_t rb_o    [2];
  regaddr_t rd_o    [2];
  u32_t     rad_o   [2];
  u32_t     rbd_o   [2];
  u32_t     imm_o   [2];
  ex_ctrl_t ctrl_o  [2];
  logic     stall_o [2];
`ifdef MINA_ID_EX_PERF_CNT_EN
  u32_t     pbub_o  [2];
  u32_t     phold_o [2];
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned stall_cycles = 0;

  localparam ex_ctrl_t C_XOR  = '{alu_op: ALU_XOR, mem_rd: 1'b0, mem_wr: 1'b0, reg_we: 1'b1};
  localparam ex_ctrl_t C_ADD  = '{alu_op: ALU_ADD, mem_rd: 1'b0, mem_wr: 1'b0, reg_we: 1'b1};
  localparam ex_ctrl_t C_LOAD = '{alu_op: ALU_ADD, mem_rd: 1'b1, mem_wr: 1'b0, reg_we: 1'b1};

  always #5 clk = ~clk;

  id_ex_stage #(.LOAD_USE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
    .ra_addr_id(ra_addr_id), .rb_addr_id(rb_addr_id), .rd_addr_id(rd_addr_id),
    .ra_data_id(ra_data_id), .rb_data_id(rb_data_id), .imm_id(imm_id), .ctrl_id(ctrl_id),
    .hold_mem(hold_mem), .flush_ex(flush_ex),
    .valid_id_ex(valid_o[0]), .ra_addr_id_ex(ra_o[0]), .rb_addr_id_ex(rb_o[0]),
    .rd_addr_id_ex(rd_o[0]), .ra_data_id_ex(rad_o[0]), .rb_data_id_ex(rbd_o[0]),
    .imm_id_ex(imm_o[0]), .ctrl_id_ex(ctrl_o[0]), .stall_id(stall_o[0])
`ifdef MINA_ID_EX_PERF_CNT_EN
    , .perf_bubbles(pbub_o[0]), .perf_holds(phold_o[0])
`endif
  );

  id_ex_stage #(.LOAD_USE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
    .ra_addr_id(ra_addr_id), .rb_addr_id(rb_addr_id), .rd_addr_id(rd_addr_id),
    .ra_data_id(ra_data_id), .rb_data_id(rb_data_id), .imm_id(imm_id), .ctrl_id(ctrl_id),
    .hold_mem(hold_mem), .flush_ex(flush_ex),
    .valid_id_ex(valid_o[1]), .ra_addr_id_ex(ra_o[1]), .rb_addr_id_ex(rb_o[1]),
    .rd_addr_id_ex(rd_o[1]), .ra_data_id_ex(rad_o[1]), .rb_data_id_ex(rbd_o[1]),
    .imm_id_ex(imm_o[1]), .ctrl_id_ex(ctrl_o[1]), .stall_id(stall_o[1])
`ifdef MINA_ID_EX_PERF_CNT_EN
    , .perf_bubbles(pbub_o[1]), .perf_holds(phold_o[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pipe(input string tag, input int d, input logic v, input regaddr_t ra,
                          input regaddr_t rd, input u32_t rad, input ex_ctrl_t c);
    chk({tag, ".valid"}, 64'(valid_o[d]), 64'(v));
    chk({tag, ".ra"},    64'(ra_o[d]),    64'(ra));
    chk({tag, ".rd"},    64'(rd_o[d]),    64'(rd));
    chk({tag, ".radat"}, 64'(rad_o[d]),   64'(rad));
    chk({tag, ".ctrl"},  64'(ctrl_o[d]),  64'(c));
  endtask

  task automatic bubble(input string tag, input int d);
    chk_pipe(tag, d, 1'b0, '0, '0, '0, EX_CTRL_NOP);
  endtask

  task automatic set_id(input logic v, input regaddr_t ra, input regaddr_t rb, input regaddr_t rd,
                        input u32_t rad, input u32_t rbd, input u32_t imm, input ex_ctrl_t c);
    valid_id = v; ra_addr_id = ra; rb_addr_id = rb; rd_addr_id = rd;
    ra_data_id = rad; rb_data_id = rbd; imm_id = imm; ctrl_id = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random operands
    rst_n = 1'b0; hold_mem = 1'b0; flush_ex = 1'b0;
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, C_LOAD);
    #2;
    tick; tick;
    for (int d = 0; d < 2; d++) begin
      bubble("rst", d);
      chk("rst.rb",    64'(rb_o[d]),    64'd0);
      chk("rst.rbdat", 64'(rbd_o[d]),   64'd0);
      chk("rst.imm",   64'(imm_o[d]),   64'd0);
      chk("rst.stall", 64'(stall_o[d]), 64'd0);
    end
    rst_n = 1'b1;

    // First real instruction after reset: one-edge latency
    set_id(1'b1, 5'd2, 5'd7, 5'd1, 32'h11, 32'h22, 32'h5, C_XOR);
    tick;
    for (int d = 0; d < 2; d++) begin
      chk_pipe("first", d, 1'b1, 5'd2, 5'd1, 32'h11, C_XOR);
      chk("first.rbdat", 64'(rbd_o[d]), 64'h22);
      chk("first.imm",   64'(imm_o[d]), 64'h5);
    end

    // Load r3, then add r5, r3, r4
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'h10, C_LOAD);
    tick;
    chk_pipe("ld", 0, 1'b1, 5'd1, 5'd3, 32'hA0, C_LOAD);
    chk_pipe("ld", 1, 1'b1, 5'd1, 5'd3, 32'hA0, C_LOAD);
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'hC0, 32'hD0, 32'h0, C_ADD);
    #1;
    chk("lu.stall0.c1", 64'(stall_o[0]), 64'd1);
    chk("lu.stall1.c1", 64'(stall_o[1]), 64'd1);
    tick;
    bubble("lu.e1.d0", 0);
    bubble("lu.e1.d1", 1);
    chk("lu.stall0.c2", 64'(stall_o[0]), 64'd0);
    chk("lu.stall1.c2", 64'(stall_o[1]), 64'd1);
    tick;
    chk_pipe("lu.e2.d0", 0, 1'b1, 5'd3, 5'd5, 32'hC0, C_ADD);
    bubble("lu.e2.d1", 1);
    chk("lu.stall1.c3", 64'(stall_o[1]), 64'd1);
    tick;
    bubble("lu.e3.d1", 1);
    chk("lu.stall1.c4", 64'(stall_o[1]), 64'd0);
    tick;
    chk_pipe("lu.e4.d1", 1, 1'b1, 5'd3, 5'd5, 32'hC0, C_ADD);

    // Load into r0 never stalls
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3, C_LOAD);
    tick;
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h7, C_ADD);
    #1;
    chk("r0.stall0", 64'(stall_o[0]), 64'd0);
    chk("r0.stall1", 64'(stall_o[1]), 64'd0);
    tick;
    chk_pipe("r0.d0", 0, 1'b1, 5'd0, 5'd6, 32'h0, C_ADD);
    chk_pipe("r0.d1", 1, 1'b1, 5'd0, 5'd6, 32'h0, C_ADD);

    // hold_mem for two cycles while LOAD_USE_CYCLES=3 instance waits with count 2
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hB1, 32'h0, C_LOAD);
    tick;
    set_id(1'b1, 5'd4, 5'd3, 5'd5, 32'hC1, 32'hD1, 32'h0, C_ADD);
    #1;
    if (stall_o[1]) stall_cycles++;
    tick;
    hold_mem = 1'b1;
    #1;
    if (stall_o[1]) stall_cycles++;
    chk("hold.stall0", 64'(stall_o[0]), 64'd1);
    tick;
    bubble("hold.h1.d1", 1);
    bubble("hold.h1.d0", 0);
    if (stall_o[1]) stall_cycles++;
    tick;
    bubble("hold.h2.d1", 1);
    hold_mem = 1'b0;
    #1;
    if (stall_o[1]) stall_cycles++;
    chk("hold.rel.stall0", 64'(stall_o[0]), 64'd0);
    tick;
    chk_pipe("hold.rel.d0", 0, 1'b1, 5'd4, 5'd5, 32'hC1, C_ADD);
    bubble("hold.r1.d1", 1);
    if (stall_o[1]) stall_cycles++;
    tick;
    bubble("hold.r2.d1", 1);
    chk("hold.r2.stall1", 64'(stall_o[1]), 64'd0);
    tick;
    chk_pipe("hold.r3.d1", 1, 1'b1, 5'd4, 5'd5, 32'hC1, C_ADD);
    chk("hold.stall_total", 64'(stall_cycles), 64'd5);

    // Flush beats hold and a pending hazard
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hA2, 32'hB2, 32'h0, C_LOAD);
    tick;
    set_id(1'b1, 5'd3, 5'd3, 5'd8, 32'hC2, 32'hD2, 32'h0, C_ADD);
    hold_mem = 1'b1; flush_ex = 1'b1;
    #1;
    chk("fl.stall0", 64'(stall_o[0]), 64'd0);
    chk("fl.stall1", 64'(stall_o[1]), 64'd0);
    tick;
    bubble("fl.d0", 0);
    bubble("fl.d1", 1);
    hold_mem = 1'b0; flush_ex = 1'b0;
    #1;
    chk("fl.post.stall0", 64'(stall_o[0]), 64'd0);
    chk("fl.post.stall1", 64'(stall_o[1]), 64'd0);
    tick;
    chk_pipe("fl.post.d0", 0, 1'b1, 5'd3, 5'd8, 32'hC2, C_ADD);
    chk_pipe("fl.post.d1", 1, 1'b1, 5'd3, 5'd8, 32'hC2, C_ADD);

`ifdef MINA_ID_EX_PERF_CNT_EN
    chk("perf.bub0",  64'(pbub_o[0]),  64'd2);
    chk("perf.bub1",  64'(pbub_o[1]),  64'd6);
    chk("perf.hold0", 64'(phold_o[0]), 64'd2);
    chk("perf.hold1", 64'(phold_o[1]), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
